// File: rtl/wb_stage.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : wb_stage
// Purpose  : RV64 writeback stage with a skid FIFO, load alignment/extension,
//            register-file write port, commit reporting and retired counter.
//            Optional macro WB_FWD_EN enables the decode bypass outputs.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module wb_stage #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [4:0]      in_rd,
    input  logic            in_wen,
    input  logic            in_is_load,
    input  logic [1:0]      in_load_size,
    input  logic            in_load_unsigned,
    input  logic [2:0]      in_byte_off,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_mem_rdata,
    input  logic            hold,
    input  logic            flush,
    output logic [4:0]      reg_w,
    output logic [XLEN-1:0] w_data,
    output logic            reg_w_ctrl,
    output logic            commit_valid,
    output logic [XLEN-1:0] commit_pc,
    output logic [63:0]     commit_count,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
);

    localparam int             c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_PTR_W:0] c_FULL = (c_PTR_W + 1)'(DEPTH);

    logic [XLEN-1:0]    r_fifo_pc  [DEPTH];
    logic [4:0]         r_fifo_rd  [DEPTH];
    logic               r_fifo_wen [DEPTH];
    logic [XLEN-1:0]    r_fifo_res [DEPTH];

    logic [c_PTR_W-1:0] r_wptr;
    logic [c_PTR_W-1:0] r_rptr;
    logic [c_PTR_W:0]   r_count;

    logic               w_push;
    logic               w_pop;
    logic [XLEN-1:0]    w_shifted;
    logic [XLEN-1:0]    w_load;
    logic [XLEN-1:0]    w_result;
    logic               w_sext;

    assign in_ready = (r_count != c_FULL);
    assign w_push   = in_valid && in_ready && !flush;
    assign w_pop    = (r_count != '0) && !hold && !flush;

    // Bytes shifted beyond the top of the doubleword fill with zero.
    assign w_shifted = in_mem_rdata >> {in_byte_off, 3'b000};

    always_comb begin
        w_load = w_shifted;
        w_sext = 1'b0;
        case (in_load_size)
            2'd0: begin
                w_sext = !in_load_unsigned && w_shifted[7];
                w_load = {{(XLEN-8){w_sext}}, w_shifted[7:0]};
            end
            2'd1: begin
                w_sext = !in_load_unsigned && w_shifted[15];
                w_load = {{(XLEN-16){w_sext}}, w_shifted[15:0]};
            end
            2'd2: begin
                w_sext = !in_load_unsigned && w_shifted[31];
                w_load = {{(XLEN-32){w_sext}}, w_shifted[31:0]};
            end
            default: begin
                w_sext = 1'b0;
                w_load = w_shifted;
            end
        endcase
    end

    assign w_result = in_is_load ? w_load : in_alu_result;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wptr]  <= in_pc;
            r_fifo_rd[r_wptr]  <= in_rd;
            r_fifo_wen[r_wptr] <= in_wen;
            r_fifo_res[r_wptr] <= w_result;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Index and data hold between pops; only the strobes drop back to zero.
    always_ff @(posedge clk) begin
        if (!rst) begin
            reg_w        <= '0;
            w_data       <= '0;
            reg_w_ctrl   <= 1'b0;
            commit_valid <= 1'b0;
            commit_pc    <= '0;
            commit_count <= '0;
        end else if (w_pop) begin
            reg_w        <= r_fifo_rd[r_rptr];
            w_data       <= r_fifo_res[r_rptr];
            reg_w_ctrl   <= r_fifo_wen[r_rptr] && (r_fifo_rd[r_rptr] != 5'd0);
            commit_valid <= 1'b1;
            commit_pc    <= r_fifo_pc[r_rptr];
            commit_count <= commit_count + 64'd1;
        end else begin
            reg_w_ctrl   <= 1'b0;
            commit_valid <= 1'b0;
        end
    end

`ifdef WB_FWD_EN
    assign fwd_valid = reg_w_ctrl;
    assign fwd_rd    = reg_w;
    assign fwd_data  = w_data;
`else
    assign fwd_valid = 1'b0;
    assign fwd_rd    = 5'd0;
    assign fwd_data  = '0;
`endif

endmodule
`default_nettype wire
